// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit with architectural HI/LO.
// Runs MULT/MULTU/DIV/DIVU over a fixed number of busy cycles and services
// MFHI/MFLO/MTHI/MTLO.
// Optional feature macro: MD_DIV0_HOLD_EN (divide by zero is dropped without
// entering RUN; HI/LO keep their values).
// Handshake: an op is taken on a rising edge when Start & ~Req & ~Busy.
// Start while Busy is ignored. Req cancels a not-yet-accepted op, but it never
// aborts an op that is already running.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        Req,
    input  logic        Start,
    input  logic [2:0]  MULTSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out,
    output logic        MD_Stall,
    output logic        state_dbg
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    logic [63:0]   calc;
    logic [31:0]   a_abs, b_abs, q_abs, r_abs;
    logic          a_neg, b_neg;
    logic          accept;

    assign accept = Start & ~Req & (state == S_IDLE);

    // Compute the 64-bit {hi,lo} result of the presented op from A/B.
    always_comb begin
        calc  = 64'd0;
        a_neg = A[31];
        b_neg = B[31];
        a_abs = a_neg ? (32'd0 - A) : A;
        b_abs = b_neg ? (32'd0 - B) : B;
        q_abs = 32'd0;
        r_abs = 32'd0;
        case (MULTSel)
            OP_MULT:  calc = {{32{A[31]}}, A} * {{32{B[31]}}, B};
            OP_MULTU: calc = {32'd0, A} * {32'd0, B};
            OP_DIV: begin
                if (B == 32'd0) begin
                    calc = {A, 32'hFFFF_FFFF};
                end else begin
                    // Magnitude divide, then restore signs: quotient truncates
                    // toward zero, remainder follows the dividend.
                    q_abs = a_abs / b_abs;
                    r_abs = a_abs % b_abs;
                    calc  = {(a_neg ? (32'd0 - r_abs) : r_abs),
                             ((a_neg ^ b_neg) ? (32'd0 - q_abs) : q_abs)};
                end
            end
            OP_DIVU: begin
                if (B == 32'd0) calc = {A, 32'hFFFF_FFFF};
                else            calc = {A % B, A / B};
            end
            default: calc = 64'd0;
        endcase
    end

    // Control FSM: accept ops in IDLE, count down in RUN, commit HI/LO at the end.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= S_IDLE;
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (MULTSel)
                            OP_MULT, OP_MULTU: begin
                                {res_hi, res_lo} <= calc;
                                cnt              <= CW'(MULT_CYCLES);
                                state            <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MD_DIV0_HOLD_EN
                                if (B != 32'd0) begin
                                    {res_hi, res_lo} <= calc;
                                    cnt              <= CW'(DIV_CYCLES);
                                    state            <= S_RUN;
                                end
`else
                                {res_hi, res_lo} <= calc;
                                cnt              <= CW'(DIV_CYCLES);
                                state            <= S_RUN;
`endif
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cnt <= CW'(1)) begin
                        HI    <= res_hi;
                        LO    <= res_lo;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Zero-latency status and read data.
    always_comb begin
        Busy      = (state == S_RUN);
        state_dbg = (state == S_RUN);
        MD_Stall  = Start | Busy;
        case (MULTSel)
            OP_MFHI: MD_out = HI;
            OP_MFLO: MD_out = LO;
            default: MD_out = 32'd0;
        endcase
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit for the pipelined MIPS core. It consumes the operands and `MULTSel`/`ISMULTDIV` fields that the D→E pipeline register presents to the E stage. It runs multi-cycle MULT/MULTU/DIV/DIVU, services MFHI/MFLO/MTHI/MTLO, and owns the architectural HI/LO registers. It reports its occupancy back to the hazard unit, which converts it into the stall and flush (`STALL_RESET`) of that same pipeline register.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: Busy cycles for DIV/DIVU (≥1).

- `clk` in 1: the single clock. All state changes on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `Req` in 1: exception/interrupt request. While high, the E-stage instruction is cancelled.
- `Start` in 1: the E-stage instruction is a mult/div-class op (E `ISMULTDIV`).
- `MULTSel` in 3: operation code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `A` in 32: rs value after forwarding.
- `B` in 32: rt value after forwarding.
- `Busy` out 1: an operation is in flight.
- `HI` out 32: architectural HI register.
- `LO` out 32: architectural LO register.
- `MD_out` out 32: combinational read data. `HI` when MULTSel=4, `LO` when MULTSel=5, otherwise 0.
- `MD_Stall` out 1: combinational `Start | Busy`. The hazard unit uses it to stall D while D holds a mult/div-class op.

## Operation
- States: IDLE (Busy=0) and RUN (Busy=1). A down-counter `cnt` and a pending 64-bit result `{res_hi,res_lo}`.
- Accept condition: `Start & ~Req & ~Busy`. Evaluated on the rising edge.
- Accepted MULT/MULTU/DIV/DIVU:
  - The result is computed from `A`/`B` at accept and captured into `res`.
  - `cnt` loads MULT_CYCLES or DIV_CYCLES, then → RUN.
- In RUN, `cnt` decrements each edge.
  - On the edge where `cnt` reaches 0: `HI<=res_hi`, `LO<=res_lo`, → IDLE.
  - `Req` in RUN does not abort; the in-flight op always completes.
- Accepted MTHI: `HI<=A` on the accept edge; no RUN. MTLO is the same for `LO`.
- MFHI/MFLO: no state change. `MD_out` supplies the data.
- `Start` with `Req=1`: ignored entirely, including MTHI/MTLO.
- `Start` while `Busy=1` is a protocol violation. It is ignored and has no state effect.
- Arithmetic:
  - MULT: signed 32×32→64, `{HI,LO}` = product.
  - MULTU: the unsigned equivalent.
  - DIV: `LO` = quotient truncated toward zero; `HI` = remainder, carrying the sign of the dividend.
  - DIVU: the unsigned equivalent.
  - DIV of 0x8000_0000 by 0xFFFF_FFFF: `LO`=0x8000_0000, `HI`=0.
- Divide by zero: see Configuration.

## Timing
- Reset (async, `RESET_N`=0): `Busy`=0, `HI`=0, `LO`=0, `cnt`=0, `res`=0, state IDLE. Takes effect immediately and holds while low.
- Reset asserted mid-RUN aborts the operation; HI/LO go to 0.
- Accept at edge T:
  - `Busy`=1 from T through edge T+N−1.
  - `Busy`=0 and new HI/LO are visible after edge T+N, where N is the cycle parameter.
- MTHI/MTLO at edge T: new value visible after T.
- `MD_out` and `MD_Stall` are purely combinational, with zero latency.
- MFHI issued in the cycle after Busy falls reads the new HI.

## Configuration
- `MD_DIV0_HOLD_EN`:
  - Defined: DIV/DIVU with `B`=0 is accepted but does not enter RUN. `Busy` stays 0 and HI/LO are unchanged.
  - Undefined: a divide by zero runs the full DIV_CYCLES and then writes `LO`=0xFFFF_FFFF and `HI`=`A`.

## Test plan
- MULT with A=0xFFFF_FFFE (−2), B=3, Start one cycle → Busy high for exactly 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
- DIV with A=0xFFFF_FFF9 (−7), B=2 → Busy 10 cycles, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU with A=7, B=2 → LO=3, HI=1.
- MTHI A=0x1234_5678, then MFHI next cycle → HI and MD_out=0x1234_5678, Busy never rises. The same sequence with Req=1 on the MTHI cycle → HI unchanged.
- MULTU A=B=0xFFFF_FFFF with Req=1 on the Start cycle → no Busy, HI/LO unchanged. Req pulsed mid-RUN of an accepted MULTU → completes with HI=0xFFFF_FFFE, LO=1.
- RESET_N pulsed low at cycle 3 of a DIV → Busy, HI, LO drop to 0 immediately, without waiting for a clock edge; no result is written afterwards.
- DIVU with B=0:
  - With `MD_DIV0_HOLD_EN` defined → Busy stays 0, HI/LO unchanged.
  - Without it → 10 Busy cycles, then LO=0xFFFF_FFFF, HI=A.
